// File: rtl/mem_wb_load_unit.sv
// MEM->WB boundary register with data-RAM load tracking.
// Captures the MEM writeback bundle, waits for the RAM response of an issued
// access, aligns and extends load data, stalls upstream while an access is in
// flight, and discards responses that belong to a flushed access.
module mem_wb_load_unit #(
    parameter int CP0_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_in,
    input  logic                      flush,
    input  logic                      mem_read_flag_in,
    input  logic                      mem_write_flag_in,
    input  logic                      mem_sign_ext_flag_in,
    input  logic [3:0]                mem_sel_in,
    input  logic [31:0]               result_in,
    input  logic                      write_reg_en_in,
    input  logic [4:0]                write_reg_addr_in,
    input  logic                      hilo_write_en_in,
    input  logic [31:0]               hi_in,
    input  logic [31:0]               lo_in,
    input  logic                      cp0_write_en_in,
    input  logic [CP0_ADDR_WIDTH-1:0] cp0_addr_in,
    input  logic [31:0]               cp0_write_data_in,
    input  logic [31:0]               debug_pc_addr_in,
    input  logic                      ram_resp_valid,
    input  logic [31:0]               ram_rdata,
    output logic                      stall_req,
    output logic                      write_reg_en_out,
    output logic [4:0]                write_reg_addr_out,
    output logic [31:0]               write_reg_data_out,
    output logic                      hilo_write_en_out,
    output logic [31:0]               hi_out,
    output logic [31:0]               lo_out,
    output logic                      cp0_write_en_out,
    output logic [CP0_ADDR_WIDTH-1:0] cp0_addr_out,
    output logic [31:0]               cp0_write_data_out,
    output logic [31:0]               debug_pc_addr_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // nothing outstanding
        S_WAIT  = 2'd1,  // access outstanding
        S_DONE  = 2'd2,  // response buffered, commit held by stall_in
        S_DRAIN = 2'd3   // flushed access outstanding, response discarded
    } state_e;

    // Writeback bundle, used both for the visible outputs and the pending copy.
    typedef struct packed {
        logic                      wr_en;
        logic [4:0]                wr_addr;
        logic [31:0]               wr_data;
        logic                      hilo_en;
        logic [31:0]               hi;
        logic [31:0]               lo;
        logic                      cp0_en;
        logic [CP0_ADDR_WIDTH-1:0] cp0_addr;
        logic [31:0]               cp0_data;
        logic [31:0]               pc;
    } wb_t;

    // Access descriptor needed to align the response.
    typedef struct packed {
        logic [1:0] addr_lo;
        logic [3:0] sel;
        logic       sext;
        logic       read;
    } acc_t;

    state_e      state_q, state_d;
    wb_t         out_q, out_d;
    wb_t         pend_q, pend_d;
    acc_t        acc_q, acc_d;
    logic [31:0] rdata_q, rdata_d;

    wb_t         in_b;
    wb_t         commit_b;
    logic [31:0] src_word;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        ext_ok;
    logic [31:0] ext_data;

    // Pack the MEM-stage inputs into a bundle.
    always_comb begin
        in_b          = '0;
        in_b.wr_en    = write_reg_en_in;
        in_b.wr_addr  = write_reg_addr_in;
        in_b.wr_data  = result_in;
        in_b.hilo_en  = hilo_write_en_in;
        in_b.hi       = hi_in;
        in_b.lo       = lo_in;
        in_b.cp0_en   = cp0_write_en_in;
        in_b.cp0_addr = cp0_addr_in;
        in_b.cp0_data = cp0_write_data_in;
        in_b.pc       = debug_pc_addr_in;
    end

    // Align and extend the response word; flag misaligned or unknown sizes.
    always_comb begin
        src_word = (state_q == S_DONE) ? rdata_q : ram_rdata;
        lane_b   = src_word[{acc_q.addr_lo, 3'b000} +: 8];
        lane_h   = src_word[{acc_q.addr_lo[1], 4'b0000} +: 16];
        ext_ok   = 1'b0;
        ext_data = '0;
        case (acc_q.sel)
            4'b0001: begin
                ext_ok   = 1'b1;
                ext_data = {{24{acc_q.sext & lane_b[7]}}, lane_b};
            end
            4'b0011: begin
                if (!acc_q.addr_lo[0]) begin
                    ext_ok   = 1'b1;
                    ext_data = {{16{acc_q.sext & lane_h[15]}}, lane_h};
                end
            end
            4'b1111: begin
                if (acc_q.addr_lo == 2'b00) begin
                    ext_ok   = 1'b1;
                    ext_data = src_word;
                end
            end
            default: ;
        endcase
    end

    // Build the bundle committed when the access completes.
    always_comb begin
        commit_b = pend_q;
        if (!ext_ok) begin
            commit_b.wr_en   = 1'b0;
            commit_b.wr_data = '0;
        end else if (acc_q.read) begin
            commit_b.wr_data = ext_data;
        end else begin
            commit_b.wr_en   = 1'b0;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d = state_q;
        out_d   = out_q;
        pend_d  = pend_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;

        if (flush) begin
            out_d  = '0;
            pend_d = '0;
            acc_d  = '0;
            case (state_q)
                S_WAIT:  state_d = ram_resp_valid ? S_IDLE : S_DRAIN;
                S_DRAIN: state_d = ram_resp_valid ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!stall_in) begin
                        if (mem_read_flag_in || mem_write_flag_in) begin
                            pend_d        = in_b;
                            acc_d.addr_lo = result_in[1:0];
                            acc_d.sel     = mem_sel_in;
                            acc_d.sext    = mem_sign_ext_flag_in;
                            acc_d.read    = mem_read_flag_in;
                            out_d.wr_en   = 1'b0;
                            out_d.hilo_en = 1'b0;
                            out_d.cp0_en  = 1'b0;
                            state_d       = S_WAIT;
                        end else begin
                            out_d = in_b;
                        end
                    end
                end
                S_WAIT: begin
                    if (ram_resp_valid) begin
                        if (!stall_in) begin
                            out_d   = commit_b;
                            state_d = S_IDLE;
                        end else begin
                            rdata_d = ram_rdata;
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!stall_in) begin
                        out_d   = commit_b;
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (ram_resp_valid) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and data registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            pend_q  <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall_req          = (state_q != S_IDLE);
    assign write_reg_en_out   = out_q.wr_en;
    assign write_reg_addr_out = out_q.wr_addr;
    assign write_reg_data_out = out_q.wr_data;
    assign hilo_write_en_out  = out_q.hilo_en;
    assign hi_out             = out_q.hi;
    assign lo_out             = out_q.lo;
    assign cp0_write_en_out   = out_q.cp0_en;
    assign cp0_addr_out       = out_q.cp0_addr;
    assign cp0_write_data_out = out_q.cp0_data;
    assign debug_pc_addr_out  = out_q.pc;

endmodule

// File: tb/tb_mem_wb_load_unit.sv
// Self-checking bench for mem_wb_load_unit: table of single accesses with a
// scoreboard queue, plus hand sequences for stall, flush and reset cases.
module tb_mem_wb_load_unit;

    logic        clk;
    logic        rst;
    logic        stall_in, flush;
    logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] result_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic        hilo_write_en_in;
    logic [31:0] hi_in, lo_in;
    logic        cp0_write_en_in;
    logic [7:0]  cp0_addr_in;
    logic [31:0] cp0_write_data_in;
    logic [31:0] debug_pc_addr_in;
    logic        ram_resp_valid;
    logic [31:0] ram_rdata;
    logic        stall_req;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic [31:0] write_reg_data_out;
    logic        hilo_write_en_out;
    logic [31:0] hi_out, lo_out;
    logic        cp0_write_en_out;
    logic [7:0]  cp0_addr_out;
    logic [31:0] cp0_write_data_out;
    logic [31:0] debug_pc_addr_out;

    mem_wb_load_unit #(.CP0_ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
        .mem_sign_ext_flag_in(mem_sign_ext_flag_in), .mem_sel_in(mem_sel_in),
        .result_in(result_in), .write_reg_en_in(write_reg_en_in),
        .write_reg_addr_in(write_reg_addr_in), .hilo_write_en_in(hilo_write_en_in),
        .hi_in(hi_in), .lo_in(lo_in), .cp0_write_en_in(cp0_write_en_in),
        .cp0_addr_in(cp0_addr_in), .cp0_write_data_in(cp0_write_data_in),
        .debug_pc_addr_in(debug_pc_addr_in), .ram_resp_valid(ram_resp_valid),
        .ram_rdata(ram_rdata), .stall_req(stall_req),
        .write_reg_en_out(write_reg_en_out), .write_reg_addr_out(write_reg_addr_out),
        .write_reg_data_out(write_reg_data_out), .hilo_write_en_out(hilo_write_en_out),
        .hi_out(hi_out), .lo_out(lo_out), .cp0_write_en_out(cp0_write_en_out),
        .cp0_addr_out(cp0_addr_out), .cp0_write_data_out(cp0_write_data_out),
        .debug_pc_addr_out(debug_pc_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd, wr, sext;
        logic [3:0]  sel;
        logic [31:0] res, rdata;
        int          delay;      // cycles without response after capture
        logic [4:0]  waddr;
        logic        exp_en;
        logic [31:0] exp_data;
        logic        chk_data;
    } vec_t;

    typedef struct {
        string       name;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // One full clock: inputs set at a negedge are captured at the next posedge,
    // and outputs are examined at the following negedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_read_flag_in     = 1'b0;
        mem_write_flag_in    = 1'b0;
        mem_sign_ext_flag_in = 1'b0;
        mem_sel_in           = 4'h0;
        result_in            = 32'h0;
        write_reg_en_in      = 1'b0;
        write_reg_addr_in    = 5'd0;
        hilo_write_en_in     = 1'b0;
        hi_in                = 32'h0;
        lo_in                = 32'h0;
        cp0_write_en_in      = 1'b0;
        cp0_addr_in          = 8'h0;
        cp0_write_data_in    = 32'h0;
        debug_pc_addr_in     = 32'h0;
    endtask

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic sext, input logic [3:0] sel,
                                input logic [31:0] res, input logic [31:0] rdata,
                                input int delay, input logic [4:0] waddr,
                                input logic exp_en, input logic [31:0] exp_data,
                                input logic chk_data);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.sext = sext; v.sel = sel;
        v.res = res; v.rdata = rdata; v.delay = delay; v.waddr = waddr;
        v.exp_en = exp_en; v.exp_data = exp_data; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow got=empty exp=entry");
        end else begin
            e = sb.pop_front();
            check({e.name, "_en"}, {31'b0, write_reg_en_out}, {31'b0, e.en});
            check({e.name, "_addr"}, {27'b0, write_reg_addr_out}, {27'b0, e.addr});
            if (e.chk_data) check({e.name, "_data"}, write_reg_data_out, e.data);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        idle_inputs();
        mem_read_flag_in     = v.rd;
        mem_write_flag_in    = v.wr;
        mem_sign_ext_flag_in = v.sext;
        mem_sel_in           = v.sel;
        result_in            = v.res;
        write_reg_en_in      = 1'b1;
        write_reg_addr_in    = v.waddr;
        debug_pc_addr_in     = v.res ^ 32'h1;
        e.name = v.name; e.en = v.exp_en; e.addr = v.waddr;
        e.data = v.exp_data; e.chk_data = v.chk_data;
        sb.push_back(e);
        cyc();
        idle_inputs();
        if (v.rd || v.wr) begin
            check({v.name, "_stall"}, {31'b0, stall_req}, 32'd1);
            check({v.name, "_bubble"}, {31'b0, write_reg_en_out}, 32'd0);
            for (int i = 0; i < v.delay; i++) begin
                cyc();
                check({v.name, "_wait_stall"}, {31'b0, stall_req}, 32'd1);
                check({v.name, "_wait_en"}, {31'b0, write_reg_en_out}, 32'd0);
            end
            ram_resp_valid = 1'b1;
            ram_rdata      = v.rdata;
            cyc();
            ram_resp_valid = 1'b0;
            ram_rdata      = 32'h0BAD0BAD;
        end
        pop_compare();
        check({v.name, "_stall_clear"}, {31'b0, stall_req}, 32'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0; stall_in = 1'b0; flush = 1'b0;
        ram_resp_valid = 1'b0; ram_rdata = 32'h0;
        idle_inputs();

        vecs.push_back(mk("alu_add",   0,0,0,4'h0,   32'h12345678,32'h0,       0, 5,1,32'h12345678,1));
        vecs.push_back(mk("lb_b1",     1,0,1,4'b0001,32'h00001001,32'h11228344,2, 6,1,32'hFFFFFF83,1));
        vecs.push_back(mk("lhu_h1",    1,0,0,4'b0011,32'h00002002,32'hBEEF0000,0, 7,1,32'h0000BEEF,1));
        vecs.push_back(mk("lh_mis",    1,0,1,4'b0011,32'h00002001,32'hBEEF8000,0, 8,0,32'h0,1));
        vecs.push_back(mk("lbu_b3",    1,0,0,4'b0001,32'h00003003,32'h80112233,0, 9,1,32'h00000080,1));
        vecs.push_back(mk("lbu_b2",    1,0,0,4'b0001,32'h00001002,32'h00F00000,1,10,1,32'h000000F0,1));
        vecs.push_back(mk("lb_b0",     1,0,1,4'b0001,32'h00003000,32'h7F0000FE,0,11,1,32'hFFFFFFFE,1));
        vecs.push_back(mk("lh_h0",     1,0,1,4'b0011,32'h00004000,32'h12348001,0,12,1,32'hFFFF8001,1));
        vecs.push_back(mk("lh_h1_pos", 1,0,1,4'b0011,32'h00004002,32'h7FFF8001,0,13,1,32'h00007FFF,1));
        vecs.push_back(mk("lw",        1,0,0,4'b1111,32'h00005000,32'hDEADBEEF,1,14,1,32'hDEADBEEF,1));
        vecs.push_back(mk("lw_mis",    1,0,0,4'b1111,32'h00005002,32'hDEADBEEF,0,15,0,32'h0,1));
        vecs.push_back(mk("lb_badsel", 1,0,1,4'b0101,32'h00005000,32'hFFFFFFFF,0,16,0,32'h0,1));
        vecs.push_back(mk("sw",        0,1,0,4'b1111,32'h00006000,32'h0,       1,17,0,32'h0,0));
        vecs.push_back(mk("alu_after", 0,0,0,4'h0,   32'hA5A5A5A5,32'h0,       0,18,1,32'hA5A5A5A5,1));

        // Reset state.
        cyc(); cyc();
        check("rst_stall", {31'b0, stall_req}, 32'd0);
        check("rst_en", {31'b0, write_reg_en_out}, 32'd0);
        check("rst_data", write_reg_data_out, 32'd0);
        check("rst_pc", debug_pc_addr_out, 32'd0);
        rst = 1'b1;
        cyc();

        // Pass-through of the whole bundle for a non-memory op.
        result_in = 32'h00C0FFEE; write_reg_en_in = 1'b1; write_reg_addr_in = 5'd3;
        hilo_write_en_in = 1'b1; hi_in = 32'h11111111; lo_in = 32'h22222222;
        cp0_write_en_in = 1'b1; cp0_addr_in = 8'h0C; cp0_write_data_in = 32'h33333333;
        debug_pc_addr_in = 32'hBFC00010;
        cyc();
        check("pt_data", write_reg_data_out, 32'h00C0FFEE);
        check("pt_hilo_en", {31'b0, hilo_write_en_out}, 32'd1);
        check("pt_hi", hi_out, 32'h11111111);
        check("pt_lo", lo_out, 32'h22222222);
        check("pt_cp0_en", {31'b0, cp0_write_en_out}, 32'd1);
        check("pt_cp0_addr", {24'b0, cp0_addr_out}, 32'h0C);
        check("pt_cp0_data", cp0_write_data_out, 32'h33333333);
        check("pt_pc", debug_pc_addr_out, 32'hBFC00010);

        // Downstream stall in IDLE holds the outputs.
        stall_in = 1'b1;
        result_in = 32'hFFFF0000; write_reg_addr_in = 5'd9; debug_pc_addr_in = 32'h4;
        cyc();
        check("hold_data", write_reg_data_out, 32'h00C0FFEE);
        check("hold_addr", {27'b0, write_reg_addr_out}, 32'd3);
        check("hold_pc", debug_pc_addr_out, 32'hBFC00010);
        stall_in = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response arrives while downstream is stalled: buffered, then committed.
        idle_inputs();
        mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h00007000;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd20;
        e.name = "lw_done"; e.en = 1'b1; e.addr = 5'd20; e.data = 32'hCAFEF00D; e.chk_data = 1'b1;
        sb.push_back(e);
        cyc();
        idle_inputs();
        stall_in = 1'b1;
        cyc();
        ram_resp_valid = 1'b1; ram_rdata = 32'hCAFEF00D;
        cyc();
        ram_resp_valid = 1'b0; ram_rdata = 32'h0BAD0BAD;
        check("done_stall", {31'b0, stall_req}, 32'd1);
        check("done_en", {31'b0, write_reg_en_out}, 32'd0);
        cyc();
        check("done_stall2", {31'b0, stall_req}, 32'd1);
        cyc();
        check("done_stall3", {31'b0, stall_req}, 32'd1);
        stall_in = 1'b0;
        cyc();
        pop_compare();
        check("done_stall_clear", {31'b0, stall_req}, 32'd0);

        // Flush while waiting: drain the orphaned response, commit nothing.
        run_vec(vecs[0]);
        idle_inputs();
        mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h00008000;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd21; debug_pc_addr_in = 32'h8;
        cyc();
        idle_inputs();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("drain_stall_t2", {31'b0, stall_req}, 32'd1);
        check("drain_data_zero", write_reg_data_out, 32'd0);
        check("drain_pc_zero", debug_pc_addr_out, 32'd0);
        cyc();
        check("drain_stall_t3", {31'b0, stall_req}, 32'd1);
        cyc();
        check("drain_stall_t4", {31'b0, stall_req}, 32'd1);
        ram_resp_valid = 1'b1; ram_rdata = 32'h55555555;
        cyc();
        ram_resp_valid = 1'b0;
        check("drain_idle", {31'b0, stall_req}, 32'd0);
        check("drain_no_en", {31'b0, write_reg_en_out}, 32'd0);
        check("drain_no_data", write_reg_data_out, 32'd0);

        // Flush coinciding with the response: straight back to IDLE.
        mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h00009000;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd22;
        cyc();
        idle_inputs();
        flush = 1'b1; ram_resp_valid = 1'b1; ram_rdata = 32'h66666666;
        cyc();
        flush = 1'b0; ram_resp_valid = 1'b0;
        check("flush_resp_idle", {31'b0, stall_req}, 32'd0);
        check("flush_resp_en", {31'b0, write_reg_en_out}, 32'd0);

        // Asynchronous reset in the middle of an access.
        run_vec(vecs[0]);
        mem_read_flag_in = 1'b1; mem_sel_in = 4'b1111; result_in = 32'h0000A000;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd23;
        cyc();
        idle_inputs();
        check("rstw_stall_before", {31'b0, stall_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstw_stall", {31'b0, stall_req}, 32'd0);
        check("rstw_data", write_reg_data_out, 32'd0);
        check("rstw_pc", debug_pc_addr_out, 32'd0);
        cyc();
        rst = 1'b1;
        ram_resp_valid = 1'b1; ram_rdata = 32'h77777777;
        cyc();
        ram_resp_valid = 1'b0;
        check("rstw_stray_stall", {31'b0, stall_req}, 32'd0);
        check("rstw_stray_en", {31'b0, write_reg_en_out}, 32'd0);
        check("rstw_stray_data", write_reg_data_out, 32'd0);

        run_vec(vecs[13]);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
